// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared constants and writeback request type
`include "Header.svh"

package regfile_wb_arbiter_pkg;

    // Register file data width, sourced from the global header.
    localparam int BUS_WIDTH  = `BUS_WIDTH;

    // Architectural register file geometry.
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // Default number of buffered ALU writebacks (power of two, >= 2).
    localparam int DEF_ALU_FIFO_DEPTH = 2;

    // One pending register file write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [BUS_WIDTH-1:0]  data;
    } wb_req_t;

endpackage

// File: rtl/Header.svh
// rtl/Header.svh - global datapath width shared by the register file and its writers
`ifndef HEADER_SVH
`define HEADER_SVH

`define BUS_WIDTH 32

`endif

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of writeback requests with visible storage
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int DEPTH = DEF_ALU_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_req_t          push_data,
    input  logic             pop,
    output wb_req_t          head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output wb_req_t          entries [DEPTH],
    output logic [DEPTH-1:0] entry_valid
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Overflow and underflow requests are ignored rather than corrupting state.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = entries[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; stale slots are masked by entry_valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_ptr] <= push_data;
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] offset;
            offset         = PTR_W'(i) - rd_ptr;
            entry_valid[i] = (CNT_W'(offset) < count);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - arbitrates ALU and load returns onto the register file write port
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ALU_FIFO_DEPTH = DEF_ALU_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [BUS_WIDTH-1:0]  alu_data,
    output logic                  alu_ready,
    input  logic                  ld_issue_valid,
    input  logic [REG_ADDR_W-1:0] ld_issue_rd,
    input  logic                  lsu_valid,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [BUS_WIDTH-1:0]  lsu_data,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] q_rs1,
    input  logic [REG_ADDR_W-1:0] q_rs2,
    output logic                  busy_rs1,
    output logic                  busy_rs2,
    output logic                  wb_wr,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [BUS_WIDTH-1:0]  wb_data
);

    localparam int CNT_W = $clog2(ALU_FIFO_DEPTH + 1);

    wb_req_t                   alu_req;
    wb_req_t                   fifo_head;
    wb_req_t                   fifo_entries [ALU_FIFO_DEPTH];
    logic [ALU_FIFO_DEPTH-1:0] fifo_entry_valid;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CNT_W-1:0]          fifo_count;
    logic                      alu_push;
    logic                      alu_win;
    logic                      lsu_win;
    logic                      alu_must_drain;
    logic [NUM_REGS-1:0]       pending;
    logic [NUM_REGS-1:0]       pending_next;

    assign alu_req.rd   = alu_rd;
    assign alu_req.data = alu_data;

    // Readiness reflects registered occupancy only; a same-cycle pop does not free a slot early.
    assign alu_ready = !fifo_full;
    assign alu_push  = alu_valid && alu_ready;

    wb_fifo #(
        .DEPTH (ALU_FIFO_DEPTH)
    ) u_alu_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (alu_push),
        .push_data   (alu_req),
        .pop         (alu_win),
        .head        (fifo_head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count),
        .entries     (fifo_entries),
        .entry_valid (fifo_entry_valid)
    );

    // Arbitration: a full ALU queue must drain first, otherwise load returns take priority.
    always_comb begin
        alu_must_drain = fifo_full && (fifo_count != '0);
        alu_win        = 1'b0;
        lsu_win        = 1'b0;
        if (alu_must_drain) begin
            alu_win = 1'b1;
        end else if (lsu_valid) begin
            lsu_win = 1'b1;
        end else if (!fifo_empty) begin
            alu_win = 1'b1;
        end
    end

    assign lsu_ready = lsu_win;

    // Write port register: latch the winner; writes to x0 are consumed without asserting wb_wr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_wr   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else if (alu_win) begin
            wb_wr   <= (fifo_head.rd != '0);
            wb_addr <= fifo_head.rd;
            wb_data <= fifo_head.data;
        end else if (lsu_win) begin
            wb_wr   <= (lsu_rd != '0);
            wb_addr <= lsu_rd;
            wb_data <= lsu_data;
        end else begin
            wb_wr   <= 1'b0;
        end
    end

    // Scoreboard next state: clear on accepted return, then set on issue so set wins a tie.
    always_comb begin
        pending_next = pending;
        if (lsu_win) begin
            pending_next[lsu_rd] = 1'b0;
        end
        if (ld_issue_valid && (ld_issue_rd != '0)) begin
            pending_next[ld_issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Outstanding-load scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Busy: outstanding load, queued ALU write, or the write committing at this cycle's negedge.
    always_comb begin
        busy_rs1 = pending[q_rs1] || (wb_wr && (wb_addr == q_rs1));
        busy_rs2 = pending[q_rs2] || (wb_wr && (wb_addr == q_rs2));
        for (int i = 0; i < ALU_FIFO_DEPTH; i++) begin
            if (fifo_entry_valid[i] && (fifo_entries[i].rd == q_rs1)) begin
                busy_rs1 = 1'b1;
            end
            if (fifo_entry_valid[i] && (fifo_entries[i].rd == q_rs2)) begin
                busy_rs2 = 1'b1;
            end
        end
        if (q_rs1 == '0) begin
            busy_rs1 = 1'b0;
        end
        if (q_rs2 == '0) begin
            busy_rs2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 alu_valid;
    logic [4:0]           alu_rd;
    logic [BUS_WIDTH-1:0] alu_data;
    logic                 alu_ready;
    logic                 ld_issue_valid;
    logic [4:0]           ld_issue_rd;
    logic                 lsu_valid;
    logic [4:0]           lsu_rd;
    logic [BUS_WIDTH-1:0] lsu_data;
    logic                 lsu_ready;
    logic [4:0]           q_rs1;
    logic [4:0]           q_rs2;
    logic                 busy_rs1;
    logic                 busy_rs2;
    logic                 wb_wr;
    logic [4:0]           wb_addr;
    logic [BUS_WIDTH-1:0] wb_data;

    int total;
    int bad;

    regfile_wb_arbiter #(
        .ALU_FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .alu_ready      (alu_ready),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_rd    (ld_issue_rd),
        .lsu_valid      (lsu_valid),
        .lsu_rd         (lsu_rd),
        .lsu_data       (lsu_data),
        .lsu_ready      (lsu_ready),
        .q_rs1          (q_rs1),
        .q_rs2          (q_rs2),
        .busy_rs1       (busy_rs1),
        .busy_rs2       (busy_rs2),
        .wb_wr          (wb_wr),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        alu_valid      = 1'b0;
        alu_rd         = '0;
        alu_data       = '0;
        ld_issue_valid = 1'b0;
        ld_issue_rd    = '0;
        lsu_valid      = 1'b0;
        lsu_rd         = '0;
        lsu_data       = '0;
        q_rs1          = '0;
        q_rs2          = '0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++; if (wb_wr !== 1'b0) begin bad++; $display("FAIL reset_wb_wr got=%0h exp=0", wb_wr); end
        total++; if (wb_addr !== 5'd0) begin bad++; $display("FAIL reset_wb_addr got=%0h exp=0", wb_addr); end
        total++; if (wb_data !== 32'h0) begin bad++; $display("FAIL reset_wb_data got=%0h exp=0", wb_data); end
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL reset_alu_ready got=%0h exp=1", alu_ready); end
        total++; if (lsu_ready !== 1'b0) begin bad++; $display("FAIL reset_lsu_ready got=%0h exp=0", lsu_ready); end
        for (int q = 0; q < 32; q++) begin
            q_rs1 = 5'(q);
            q_rs2 = 5'(31 - q);
            #1;
            total++; if (busy_rs1 !== 1'b0) begin bad++; $display("FAIL reset_busy_rs1 q=%0d got=%0h exp=0", q, busy_rs1); end
            total++; if (busy_rs2 !== 1'b0) begin bad++; $display("FAIL reset_busy_rs2 q=%0d got=%0h exp=0", 31 - q, busy_rs2); end
        end
        drive_idle();
    endtask

    task automatic test_alu_only();
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEADBEEF;
        q_rs1     = 5'd5;
        #1;
        total++; if (busy_rs1 !== 1'b0) begin bad++; $display("FAIL alu_busy_before_accept got=%0h exp=0", busy_rs1); end
        tick();
        alu_valid = 1'b0;
        #1;
        total++; if (busy_rs1 !== 1'b1) begin bad++; $display("FAIL alu_busy_queued got=%0h exp=1", busy_rs1); end
        total++; if (wb_wr !== 1'b0) begin bad++; $display("FAIL alu_wr_early got=%0h exp=0", wb_wr); end
        tick();
        total++; if (wb_wr !== 1'b1) begin bad++; $display("FAIL alu_wr got=%0h exp=1", wb_wr); end
        total++; if (wb_addr !== 5'd5) begin bad++; $display("FAIL alu_addr got=%0h exp=5", wb_addr); end
        total++; if (wb_data !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_data got=%0h exp=deadbeef", wb_data); end
        total++; if (busy_rs1 !== 1'b1) begin bad++; $display("FAIL alu_busy_wr_cycle got=%0h exp=1", busy_rs1); end
        tick();
        total++; if (wb_wr !== 1'b0) begin bad++; $display("FAIL alu_wr_single got=%0h exp=0", wb_wr); end
        total++; if (busy_rs1 !== 1'b0) begin bad++; $display("FAIL alu_busy_after got=%0h exp=0", busy_rs1); end
        total++; if (wb_addr !== 5'd5) begin bad++; $display("FAIL alu_addr_hold got=%0h exp=5", wb_addr); end
        total++; if (wb_data !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_data_hold got=%0h exp=deadbeef", wb_data); end
        drive_idle();
    endtask

    task automatic test_collision();
        lsu_valid = 1'b1;
        lsu_rd    = 5'd7;
        lsu_data  = 32'h11;
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 32'h22;
        #1;
        total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL coll_lsu_ready got=%0h exp=1", lsu_ready); end
        tick();
        drive_idle();
        total++; if (wb_wr !== 1'b1) begin bad++; $display("FAIL coll_wr1 got=%0h exp=1", wb_wr); end
        total++; if (wb_addr !== 5'd7) begin bad++; $display("FAIL coll_addr1 got=%0h exp=7", wb_addr); end
        total++; if (wb_data !== 32'h11) begin bad++; $display("FAIL coll_data1 got=%0h exp=11", wb_data); end
        tick();
        total++; if (wb_wr !== 1'b1) begin bad++; $display("FAIL coll_wr2 got=%0h exp=1", wb_wr); end
        total++; if (wb_addr !== 5'd3) begin bad++; $display("FAIL coll_addr2 got=%0h exp=3", wb_addr); end
        total++; if (wb_data !== 32'h22) begin bad++; $display("FAIL coll_data2 got=%0h exp=22", wb_data); end
        tick();
        total++; if (wb_wr !== 1'b0) begin bad++; $display("FAIL coll_idle got=%0h exp=0", wb_wr); end
    endtask

    task automatic test_full_priority();
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hA0;
        alu_valid = 1'b1; alu_rd = 5'd1;  alu_data = 32'h101;
        #1;
        total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL full_lsu_ready0 got=%0h exp=1", lsu_ready); end
        tick();
        total++; if (wb_addr !== 5'd10 || wb_wr !== 1'b1) begin bad++; $display("FAIL full_w0 got=%0h/%0h exp=a/1", wb_addr, wb_wr); end
        lsu_rd = 5'd11; lsu_data = 32'hA1;
        alu_rd = 5'd2;  alu_data = 32'h102;
        #1;
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL full_alu_ready1 got=%0h exp=1", alu_ready); end
        total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL full_lsu_ready1 got=%0h exp=1", lsu_ready); end
        tick();
        total++; if (wb_addr !== 5'd11 || wb_data !== 32'hA1) begin bad++; $display("FAIL full_w1 got=%0h/%0h exp=b/a1", wb_addr, wb_data); end
        lsu_rd = 5'd12; lsu_data = 32'hA2;
        alu_valid = 1'b0;
        #1;
        total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL full_alu_ready_full got=%0h exp=0", alu_ready); end
        total++; if (lsu_ready !== 1'b0) begin bad++; $display("FAIL full_lsu_blocked got=%0h exp=0", lsu_ready); end
        tick();
        total++; if (wb_addr !== 5'd1 || wb_data !== 32'h101 || wb_wr !== 1'b1) begin bad++; $display("FAIL full_w2 got=%0h/%0h exp=1/101", wb_addr, wb_data); end
        #1;
        total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL full_lsu_ready3 got=%0h exp=1", lsu_ready); end
        tick();
        total++; if (wb_addr !== 5'd12 || wb_data !== 32'hA2) begin bad++; $display("FAIL full_w3 got=%0h/%0h exp=c/a2", wb_addr, wb_data); end
        lsu_valid = 1'b0;
        tick();
        total++; if (wb_addr !== 5'd2 || wb_data !== 32'h102 || wb_wr !== 1'b1) begin bad++; $display("FAIL full_w4 got=%0h/%0h exp=2/102", wb_addr, wb_data); end
        tick();
        total++; if (wb_wr !== 1'b0) begin bad++; $display("FAIL full_drained_wr got=%0h exp=0", wb_wr); end
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL full_drained_ready got=%0h exp=1", alu_ready); end
        drive_idle();
    endtask

    task automatic test_scoreboard();
        q_rs2 = 5'd9;
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd9;
        #1;
        total++; if (busy_rs2 !== 1'b0) begin bad++; $display("FAIL sb_busy_pre got=%0h exp=0", busy_rs2); end
        tick();
        ld_issue_valid = 1'b0;
        #1;
        total++; if (busy_rs2 !== 1'b1) begin bad++; $display("FAIL sb_busy_set got=%0h exp=1", busy_rs2); end
        tick();
        total++; if (busy_rs2 !== 1'b1) begin bad++; $display("FAIL sb_busy_hold got=%0h exp=1", busy_rs2); end
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
        #1;
        total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL sb_ret_ready got=%0h exp=1", lsu_ready); end
        tick();
        lsu_valid = 1'b0;
        #1;
        total++; if (wb_wr !== 1'b1 || wb_addr !== 5'd9 || wb_data !== 32'h99) begin bad++; $display("FAIL sb_ret_write got=%0h/%0h exp=1/9", wb_wr, wb_addr); end
        total++; if (busy_rs2 !== 1'b1) begin bad++; $display("FAIL sb_busy_commit got=%0h exp=1", busy_rs2); end
        tick();
        total++; if (busy_rs2 !== 1'b0) begin bad++; $display("FAIL sb_busy_cleared got=%0h exp=0", busy_rs2); end
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd9;
        tick();
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h98;
        tick();
        ld_issue_valid = 1'b0;
        lsu_valid = 1'b0;
        #1;
        total++; if (busy_rs2 !== 1'b1) begin bad++; $display("FAIL sb_set_wins got=%0h exp=1", busy_rs2); end
        tick();
        total++; if (busy_rs2 !== 1'b1) begin bad++; $display("FAIL sb_set_wins_hold got=%0h exp=1", busy_rs2); end
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h97;
        tick();
        lsu_valid = 1'b0;
        tick();
        total++; if (busy_rs2 !== 1'b0) begin bad++; $display("FAIL sb_final_clear got=%0h exp=0", busy_rs2); end
        drive_idle();
    endtask

    task automatic test_x0();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd0;
        q_rs1 = 5'd0;
        tick();
        alu_valid = 1'b0;
        ld_issue_valid = 1'b0;
        #1;
        total++; if (busy_rs1 !== 1'b0) begin bad++; $display("FAIL x0_busy got=%0h exp=0", busy_rs1); end
        total++; if (wb_wr !== 1'b0) begin bad++; $display("FAIL x0_wr_a got=%0h exp=0", wb_wr); end
        tick();
        total++; if (wb_wr !== 1'b0) begin bad++; $display("FAIL x0_wr_b got=%0h exp=0", wb_wr); end
        tick();
        total++; if (wb_wr !== 1'b0) begin bad++; $display("FAIL x0_wr_c got=%0h exp=0", wb_wr); end
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL x0_popped got=%0h exp=1", alu_ready); end
        drive_idle();
    endtask

    task automatic test_reset_midop();
        lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'hC0;
        alu_valid = 1'b1; alu_rd = 5'd6;  alu_data = 32'h6;
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd4;
        q_rs1 = 5'd4; q_rs2 = 5'd6;
        tick();
        ld_issue_valid = 1'b0;
        alu_rd = 5'd8; alu_data = 32'h8;
        tick();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        #1;
        total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL mid_full got=%0h exp=0", alu_ready); end
        total++; if (busy_rs1 !== 1'b1) begin bad++; $display("FAIL mid_pending4 got=%0h exp=1", busy_rs1); end
        total++; if (busy_rs2 !== 1'b1) begin bad++; $display("FAIL mid_queued6 got=%0h exp=1", busy_rs2); end
        total++; if (wb_wr !== 1'b1 || wb_addr !== 5'd20) begin bad++; $display("FAIL mid_wr_pre got=%0h/%0h exp=1/14", wb_wr, wb_addr); end
        q_rs2 = 5'd8;
        #1;
        total++; if (busy_rs2 !== 1'b1) begin bad++; $display("FAIL mid_queued8 got=%0h exp=1", busy_rs2); end
        rst = 1'b1;
        #1;
        total++; if (wb_wr !== 1'b0) begin bad++; $display("FAIL mid_rst_wr got=%0h exp=0", wb_wr); end
        total++; if (wb_addr !== 5'd0) begin bad++; $display("FAIL mid_rst_addr got=%0h exp=0", wb_addr); end
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%0h exp=1", alu_ready); end
        total++; if (busy_rs1 !== 1'b0) begin bad++; $display("FAIL mid_rst_pending got=%0h exp=0", busy_rs1); end
        total++; if (busy_rs2 !== 1'b0) begin bad++; $display("FAIL mid_rst_fifo got=%0h exp=0", busy_rs2); end
        tick();
        rst = 1'b0;
        q_rs2 = 5'd6;
        tick();
        total++; if (wb_wr !== 1'b0) begin bad++; $display("FAIL mid_after_wr got=%0h exp=0", wb_wr); end
        total++; if (busy_rs2 !== 1'b0) begin bad++; $display("FAIL mid_after_busy got=%0h exp=0", busy_rs2); end
        drive_idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive_idle();
        test_reset();
        test_alu_only();
        test_collision();
        test_full_priority();
        test_scoreboard();
        test_x0();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two producers: ALU writeback and load/store unit (LSU) load return.
- Keeps a load scoreboard of destination registers with outstanding loads, plus a small ALU writeback FIFO.
- Drives the register file's wr / addr_rd / rd inputs.
- Gives decode a combinational busy flag for each source register, used for stalling.

Parameters:
- BUS_WIDTH, from Header.svh (32): data width of register file and write data.
- ALU_FIFO_DEPTH, 2: number of ALU writeback entries buffered; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  5  ALU destination register.
- alu_data  in  BUS_WIDTH  ALU result.
- alu_ready  out  1  ALU FIFO can accept.
- ld_issue_valid  in  1  a load is issued to memory this cycle.
- ld_issue_rd  in  5  destination of the issued load.
- lsu_valid  in  1  load data returning.
- lsu_rd  in  5  load destination register.
- lsu_data  in  BUS_WIDTH  load data.
- lsu_ready  out  1  load return accepted this cycle.
- q_rs1  in  5  decode source register 1 query.
- q_rs2  in  5  decode source register 2 query.
- busy_rs1  out  1  rs1 has a pending write.
- busy_rs2  out  1  rs2 has a pending write.
- wb_wr  out  1  register file write enable.
- wb_addr  out  5  register file write address.
- wb_data  out  BUS_WIDTH  register file write data.

Behaviour:
- Reset (rst=1, async):
  - ALU FIFO empty; pending vector = 0.
  - wb_wr=0, wb_addr=0, wb_data=0; alu_ready=1.
  - Reset mid-operation discards all queued ALU entries and outstanding-load marks.
- ALU FIFO:
  - Push when alu_valid && alu_ready.
  - alu_ready = !full, registered-state based; it does not look ahead to a same-cycle pop.
  - Pointers wrap modulo ALU_FIFO_DEPTH; a count register distinguishes full from empty.
  - Push and pop in the same cycle leave the count unchanged.
- Arbitration, evaluated combinationally each cycle:
  - If the FIFO is full and non-empty, the ALU head wins: lsu_ready=0.
  - Otherwise, if lsu_valid, the LSU wins: lsu_ready=1, no ALU pop.
  - Otherwise, if the FIFO is non-empty, the ALU head wins.
  - Otherwise, idle.
  - The LSU must hold lsu_valid/lsu_rd/lsu_data stable until lsu_ready.
- Write port (registered, 1-cycle latency):
  - The winner's rd/data are latched into wb_addr/wb_data at posedge.
  - wb_wr=1 for exactly one cycle per win.
  - The register file commits on the following negedge.
  - If the winner's rd==0, it is consumed (popped / lsu_ready=1) but wb_wr=0.
  - When idle, wb_wr=0 and wb_addr/wb_data hold their values.
- Scoreboard (32-bit pending vector, bit 0 never set):
  - Set: ld_issue_valid && ld_issue_rd!=0 → pending[ld_issue_rd]=1 at posedge.
  - Clear: an accepted LSU return clears pending[lsu_rd].
  - Simultaneous set and clear of the same register: set wins.
  - A load issued to an already-pending register stays pending; one return clears it, and in-order LSU returns are required.
- Busy (combinational):
  - busy_rsN = pending[q_rsN], OR any valid ALU FIFO entry with rd==q_rsN, OR (wb_wr && wb_addr==q_rsN).
  - The last term covers the write that commits at this cycle's negedge.
  - q_rsN==0 always gives busy=0.

Decomposition:
- Shared package: ALU_FIFO_DEPTH default, REG_ADDR_W=5, NUM_REGS=32; BUS_WIDTH stays in Header.svh.
- Package typedef wb_req_t {logic [4:0] rd; logic [BUS_WIDTH-1:0] data;}.
- One sub-module, wb_fifo: parameterised sync FIFO of wb_req_t with push/pop/full/empty/count.
- wb_fifo exposes its entry array for the busy compare.

Test Plan:
- Reset: rst=1 then 0 → wb_wr=0, wb_addr=0, wb_data=0, alu_ready=1, busy_rs1=busy_rs2=0 for every query 0..31.
- ALU only: alu_valid rd=5 data=0xDEADBEEF for 1 cycle → next cycle wb_wr=1, wb_addr=5, wb_data=0xDEADBEEF, then wb_wr=0; busy_rs1 (q_rs1=5) high from accept through the wb_wr cycle.
- Collision: lsu rd=7 data=0x11 and alu rd=3 data=0x22 in same cycle, FIFO empty → writes to 7 (cycle N+1) then 3 (cycle N+2).
- Full-FIFO priority: fill FIFO with rd=1,2 while lsu_valid is held continuously → ALU head rd=1 wins (lsu_ready=0), then LSU wins, alternating until drained.
- Scoreboard: issue load rd=9 → busy=1 for q=9; return rd=9 accepted → bit clears; same-cycle issue rd=9 and return rd=9 → busy stays 1.
- x0 and reset mid-op: ALU rd=0 → popped, wb_wr never 1; with 2 FIFO entries and pending[4]=1, assert rst → FIFO empty, pending=0, wb_wr=0 immediately (asynchronous).
